// File: rtl/axi_lite_reg_sequencer.sv
// axi_lite_reg_sequencer: AXI-Lite target that round-robins reads/writes onto one register bus
module axi_lite_reg_sequencer #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_axiTarget_arvalid,
   output logic              io_axiTarget_arready,
   input  logic [31:0]       io_axiTarget_araddr,
   output logic              io_axiTarget_rvalid,
   input  logic              io_axiTarget_rready,
   output logic [31:0]       io_axiTarget_rdata,
   output logic [1:0]        io_axiTarget_rresp,
   input  logic              io_axiTarget_awvalid,
   output logic              io_axiTarget_awready,
   input  logic [31:0]       io_axiTarget_awaddr,
   input  logic              io_axiTarget_wvalid,
   output logic              io_axiTarget_wready,
   input  logic [31:0]       io_axiTarget_wdata,
   output logic              io_axiTarget_bvalid,
   input  logic              io_axiTarget_bready,
   output logic [1:0]        io_axiTarget_bresp,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [31:0]       reg_wdata,
   output logic              reg_wen,
   output logic              reg_ren,
   input  logic [31:0]       reg_rdata,
   input  logic              reg_ack,
   input  logic              reg_err
);
   typedef enum logic [2:0] {IDLE, RD_ACC, WR_ACC, RD_RESP, WR_RESP} state_t;
   state_t state_q, state_d;
   logic ar_held_q, aw_held_q, w_held_q, ar_held_d, aw_held_d, w_held_d;
   logic arready_q, awready_q, wready_q, last_wr_q;
   logic [31:0] araddr_q, awaddr_q, wdata_q, cnt_q, rdata_q, wd_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0] resp_q;
   logic ar_hs, aw_hs, w_hs, wr_el, gnt_rd, gnt_wr, rd_bad, wr_bad, acc, tmo, done;
   assign ar_hs  = io_axiTarget_arvalid & arready_q;
   assign aw_hs  = io_axiTarget_awvalid & awready_q;
   assign w_hs   = io_axiTarget_wvalid & wready_q;
   assign wr_el  = aw_held_q & w_held_q;
   assign gnt_rd = (state_q == IDLE) && ar_held_q && (!wr_el || last_wr_q);
   assign gnt_wr = (state_q == IDLE) && wr_el && (!ar_held_q || !last_wr_q);
   assign rd_bad = (|araddr_q[31:ADDR_W+2]) | (|araddr_q[1:0]);
   assign wr_bad = (|awaddr_q[31:ADDR_W+2]) | (|awaddr_q[1:0]);
   assign acc    = (state_q == RD_ACC) || (state_q == WR_ACC);
   assign tmo    = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));
   assign done   = reg_err | reg_ack | tmo;
   assign ar_held_d = (ar_held_q & !gnt_rd) | ar_hs;
   assign aw_held_d = (aw_held_q & !gnt_wr) | aw_hs;
   assign w_held_d  = (w_held_q & !gnt_wr) | w_hs;
   assign io_axiTarget_arready = arready_q;
   assign io_axiTarget_awready = awready_q;
   assign io_axiTarget_wready  = wready_q;
   assign io_axiTarget_rdata   = rdata_q;
   assign io_axiTarget_rresp   = resp_q;
   assign io_axiTarget_bresp   = resp_q;
   assign reg_addr  = addr_q;
   assign reg_wdata = wd_q;

   // FSM state register
   always_ff @(posedge clock)
      state_q <= reset ? IDLE : state_d;

   // FSM next state: grant in IDLE, wait for ack/err/timeout, then for the response handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = gnt_rd ? (rd_bad ? RD_RESP : RD_ACC) : gnt_wr ? (wr_bad ? WR_RESP : WR_ACC) : IDLE;
         RD_ACC:  state_d = done ? RD_RESP : RD_ACC;
         WR_ACC:  state_d = done ? WR_RESP : WR_ACC;
         RD_RESP: state_d = io_axiTarget_rready ? IDLE : RD_RESP;
         WR_RESP: state_d = io_axiTarget_bready ? IDLE : WR_RESP;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: strobes and valids follow the state directly
   always_comb begin
      reg_ren             = state_q == RD_ACC;
      reg_wen             = state_q == WR_ACC;
      io_axiTarget_rvalid = state_q == RD_RESP;
      io_axiTarget_bvalid = state_q == WR_RESP;
   end

   // Channel capture, grant bookkeeping, access counter and response data
   always_ff @(posedge clock) begin
      if (reset) begin
         ar_held_q <= 1'b0;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         arready_q <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         last_wr_q <= 1'b1;
         araddr_q  <= '0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         rdata_q   <= '0;
         resp_q    <= '0;
         addr_q    <= '0;
         wd_q      <= '0;
      end else begin
         ar_held_q <= ar_held_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         arready_q <= !ar_held_d;
         awready_q <= !aw_held_d;
         wready_q  <= !w_held_d;
         if (ar_hs) araddr_q <= io_axiTarget_araddr;
         if (aw_hs) awaddr_q <= io_axiTarget_awaddr;
         if (w_hs) wdata_q <= io_axiTarget_wdata;
         cnt_q <= (acc && !done) ? cnt_q + 32'd1 : '0;
         if (gnt_rd || gnt_wr) begin
            last_wr_q <= gnt_wr;
            addr_q    <= gnt_rd ? araddr_q[ADDR_W+1:2] : awaddr_q[ADDR_W+1:2];
            resp_q    <= (gnt_rd ? rd_bad : wr_bad) ? 2'b11 : 2'b00;
            rdata_q   <= '0;
            if (gnt_wr) wd_q <= wdata_q;
         end
         if (acc && done) begin
            resp_q  <= reg_err ? 2'b10 : reg_ack ? 2'b00 : 2'b10;
            rdata_q <= (state_q == RD_ACC && reg_ack && !reg_err) ? reg_rdata : '0;
         end
         if (state_q == RD_RESP && io_axiTarget_rready) rdata_q <= '0;
      end
   end
endmodule

// File: tb/tb_axi_lite_reg_sequencer.sv
// tb_axi_lite_reg_sequencer: directed self-checking bench for axi_lite_reg_sequencer
module tb_axi_lite_reg_sequencer;
   logic clock = 1'b0, reset = 1'b1;
   logic arvalid = 0, rready = 0, awvalid = 0, wvalid = 0, bready = 0;
   logic [31:0] araddr = 0, awaddr = 0, wdata = 0, rd_val = 0;
   logic arready, rvalid, awready, wready, bvalid, reg_wen, reg_ren, reg_ack, reg_err;
   logic [31:0] rdata, reg_wdata;
   logic [1:0] rresp, bresp;
   logic [7:0] reg_addr;
   logic ack_m = 0, err_m = 0;
   int n_cmp = 0, n_err = 0;

   assign reg_ack = ack_m & (reg_ren | reg_wen);
   assign reg_err = err_m & (reg_ren | reg_wen);

   axi_lite_reg_sequencer dut (
      .clock(clock), .reset(reset),
      .io_axiTarget_arvalid(arvalid), .io_axiTarget_arready(arready), .io_axiTarget_araddr(araddr),
      .io_axiTarget_rvalid(rvalid), .io_axiTarget_rready(rready), .io_axiTarget_rdata(rdata),
      .io_axiTarget_rresp(rresp), .io_axiTarget_awvalid(awvalid), .io_axiTarget_awready(awready),
      .io_axiTarget_awaddr(awaddr), .io_axiTarget_wvalid(wvalid), .io_axiTarget_wready(wready),
      .io_axiTarget_wdata(wdata), .io_axiTarget_bvalid(bvalid), .io_axiTarget_bready(bready),
      .io_axiTarget_bresp(bresp), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wen(reg_wen),
      .reg_ren(reg_ren), .reg_rdata(rd_val), .reg_ack(reg_ack), .reg_err(reg_err)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_rd(input logic [31:0] a, input int hold, output logic [31:0] d, output logic [1:0] r,
                        output int nren, output int lat, output logic [31:0] ra, output logic st);
      int t;
      t = 0; ra = 0; nren = 0; lat = 0; st = 1'b1;
      arvalid = 1'b1; araddr = a;
      while (!arready && t < 50) begin step; t++; end
      step;
      arvalid = 1'b0;
      while (!rvalid && lat < 200) begin
         if (reg_ren) begin nren++; ra = 32'(reg_addr); end
         step; lat++;
      end
      d = rdata; r = rresp;
      repeat (hold) begin
         step;
         if (!rvalid || rdata !== d || rresp !== r) st = 1'b0;
      end
      rready = 1'b1; step; rready = 1'b0;
   endtask

   task automatic do_wr(input logic [31:0] a, input logic [31:0] dv, input int lead, output logic [1:0] r,
                        output int nwen, output logic [31:0] ra, output logic [31:0] rwd, output logic ok);
      int t, lat;
      t = 0; lat = 0; nwen = 0; ra = 0; rwd = 0; ok = 1'b1;
      wvalid = 1'b1; wdata = dv;
      if (lead > 0) begin
         while (!wready && t < 50) begin step; t++; end
         step;
         wvalid = 1'b0;
         repeat (lead - 1) begin if (wready) ok = 1'b0; step; end
         if (wready) ok = 1'b0;
         awvalid = 1'b1; awaddr = a;
         while (!awready && t < 100) begin step; t++; end
         step;
         awvalid = 1'b0;
         if (wready) ok = 1'b0;
      end else begin
         awvalid = 1'b1; awaddr = a;
         while (!(awready && wready) && t < 50) begin step; t++; end
         step;
         awvalid = 1'b0; wvalid = 1'b0;
      end
      while (!bvalid && lat < 200) begin
         if (reg_wen) begin nwen++; ra = 32'(reg_addr); rwd = reg_wdata; end
         step; lat++;
      end
      r = bresp;
      bready = 1'b1; step; bready = 1'b0;
   endtask

   initial begin
      logic [31:0] d, ra, rwd;
      logic [1:0] r;
      logic st, ok, pr, pw, bad;
      logic [3:0] seq;
      int nren, nwen, lat, nev, t;
      repeat (3) step;
      chk("rst_arready", 32'(arready), 0);
      chk("rst_awready", 32'(awready), 0);
      chk("rst_wready", 32'(wready), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_bvalid", 32'(bvalid), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_resp", 32'({rresp, bresp}), 0);
      chk("rst_strobes", 32'({reg_ren, reg_wen}), 0);
      chk("rst_reg_addr", 32'(reg_addr), 0);
      chk("rst_reg_wdata", reg_wdata, 0);
      reset = 1'b0;
      step;
      chk("post_rst_ready", 32'({arready, awready, wready}), 32'h7);

      ack_m = 1'b1; rd_val = 32'hDEADBEEF;
      do_rd(32'h10, 0, d, r, nren, lat, ra, st);
      chk("rd_ren_cycles", 32'(nren), 1);
      chk("rd_reg_addr", ra, 4);
      chk("rd_latency", 32'(lat), 2);
      chk("rd_rdata", d, 32'hDEADBEEF);
      chk("rd_rresp", 32'(r), 0);
      chk("rd_rvalid_after", 32'(rvalid), 0);
      chk("rd_rdata_after", rdata, 0);

      do_wr(32'h8, 32'h12345678, 3, r, nwen, ra, rwd, ok);
      chk("wr_wready_low", 32'(ok), 1);
      chk("wr_wen_cycles", 32'(nwen), 1);
      chk("wr_reg_addr", ra, 2);
      chk("wr_reg_wdata", rwd, 32'h12345678);
      chk("wr_bresp", 32'(r), 0);
      chk("wr_ready_back", 32'({awready, wready}), 32'h3);
      chk("wr_bvalid_after", 32'(bvalid), 0);

      seq = 4'b0; nev = 0; pr = 1'b0; pw = 1'b0;
      rready = 1'b1; bready = 1'b1;
      repeat (2) begin
         arvalid = 1'b1; araddr = 32'h14; awvalid = 1'b1; awaddr = 32'h18; wvalid = 1'b1; wdata = 32'hA5A5;
         t = 0;
         while (!(arready && awready && wready) && t < 50) begin step; t++; end
         step;
         arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
         repeat (12) begin
            if (reg_ren && !pr) begin seq = {seq[2:0], 1'b0}; nev++; end
            if (reg_wen && !pw) begin seq = {seq[2:0], 1'b1}; nev++; end
            pr = reg_ren; pw = reg_wen;
            step;
         end
      end
      rready = 1'b0; bready = 1'b0;
      chk("rr_grant_count", 32'(nev), 4);
      chk("rr_grant_order", 32'(seq), 32'h5);

      ack_m = 1'b0;
      do_rd(32'h20, 0, d, r, nren, lat, ra, st);
      chk("tmo_ren_cycles", 32'(nren), 64);
      chk("tmo_latency", 32'(lat), 65);
      chk("tmo_rresp", 32'(r), 2);
      chk("tmo_rdata", d, 0);

      ack_m = 1'b1;
      do_rd(32'h400, 0, d, r, nren, lat, ra, st);
      chk("dec_rd_strobes", 32'(nren), 0);
      chk("dec_rd_rresp", 32'(r), 3);
      chk("dec_rd_rdata", d, 0);
      chk("dec_rd_latency", 32'(lat), 1);
      do_wr(32'h2, 32'h1, 0, r, nwen, ra, rwd, ok);
      chk("dec_wr_strobes", 32'(nwen), 0);
      chk("dec_wr_bresp", 32'(r), 3);

      err_m = 1'b1; rd_val = 32'hCAFEF00D;
      do_rd(32'h30, 0, d, r, nren, lat, ra, st);
      chk("err_wins_rresp", 32'(r), 2);
      chk("err_wins_rdata", d, 0);
      err_m = 1'b0;

      rd_val = 32'h600DF00D;
      do_rd(32'h3C, 10, d, r, nren, lat, ra, st);
      chk("hold_stable", 32'(st), 1);
      chk("hold_rdata", d, 32'h600DF00D);
      chk("hold_reg_addr", ra, 15);
      chk("hold_rvalid_after", 32'(rvalid), 0);
      chk("hold_rdata_after", rdata, 0);

      ack_m = 1'b0;
      awvalid = 1'b1; awaddr = 32'h4; wvalid = 1'b1; wdata = 32'h55;
      t = 0;
      while (!(awready && wready) && t < 50) begin step; t++; end
      step;
      awvalid = 1'b0; wvalid = 1'b0;
      t = 0;
      while (!reg_wen && t < 20) begin step; t++; end
      chk("rstmid_wen_seen", 32'(reg_wen), 1);
      step;
      reset = 1'b1;
      step;
      chk("rstmid_wen", 32'(reg_wen), 0);
      chk("rstmid_bvalid", 32'(bvalid), 0);
      reset = 1'b0;
      bad = 1'b0;
      bready = 1'b1;
      repeat (80) begin step; if (bvalid || reg_wen || reg_ren) bad = 1'b1; end
      bready = 1'b0;
      chk("rstmid_no_b", 32'(bad), 0);

      ack_m = 1'b1; rd_val = 32'h11223344;
      do_rd(32'h10, 0, d, r, nren, lat, ra, st);
      chk("post_rstmid_rdata", d, 32'h11223344);
      chk("post_rstmid_rresp", 32'(r), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
